// File: rtl/frame_ram_arbiter_pkg.sv
// rtl/frame_ram_arbiter_pkg.sv - shared widths, defaults and clear FSM encoding
package frame_ram_arbiter_pkg;

    localparam int COLOR_WIDTH  = 8;
    localparam int LOG2NUM_COLS = 10;
    localparam int LOG2NUM_ROWS = 10;
    localparam int FB_COL_W     = 8;
    localparam int FB_ROW_W     = 8;
    localparam int PIX_W        = 3 * COLOR_WIDTH;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clear_state_t;

endpackage

// File: rtl/frame_ram_arbiter_if.sv
// rtl/frame_ram_arbiter_if.sv - display, writer, clear and RAM signals of the arbiter
interface frame_ram_arbiter_if
    import frame_ram_arbiter_pkg::*;
#(
    parameter int COL_W = FB_COL_W,
    parameter int ROW_W = FB_ROW_W
);
    logic                     disp_req;
    logic [LOG2NUM_COLS-1:0]  disp_x;
    logic [LOG2NUM_ROWS-1:0]  disp_y;
    logic [COLOR_WIDTH-1:0]   r;
    logic [COLOR_WIDTH-1:0]   g;
    logic [COLOR_WIDTH-1:0]   b;
    logic                     pix_valid;

    logic                     wr_valid;
    logic                     wr_ready;
    logic [COL_W+ROW_W-1:0]   wr_addr;
    logic [PIX_W-1:0]         wr_data;

    logic                     clear_start;
    logic [PIX_W-1:0]         clear_color;
    logic                     clear_busy;
    logic                     clear_done;

    logic [COL_W+ROW_W-1:0]   ram_addr;
    logic                     ram_we;
    logic [PIX_W-1:0]         ram_wdata;
    logic [PIX_W-1:0]         ram_rdata;

    modport slave (
        input  disp_req, disp_x, disp_y, wr_valid, wr_addr, wr_data,
               clear_start, clear_color, ram_rdata,
        output r, g, b, pix_valid, wr_ready, clear_busy, clear_done,
               ram_addr, ram_we, ram_wdata
    );

    modport master (
        output disp_req, disp_x, disp_y, wr_valid, wr_addr, wr_data,
               clear_start, clear_color, ram_rdata,
        input  r, g, b, pix_valid, wr_ready, clear_busy, clear_done,
               ram_addr, ram_we, ram_wdata
    );

endinterface

// File: rtl/frame_ram_arbiter_clear_seq.sv
// rtl/frame_ram_arbiter_clear_seq.sv - clear sweep address counter with end-of-sweep pulse
module frame_clear_seq
    import frame_ram_arbiter_pkg::*;
#(
    parameter int AW = FB_COL_W + FB_ROW_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_restart,
    input  logic          i_advance,
    output logic [AW-1:0] o_addr,
    output logic          o_last,
    output logic          o_done
);
    logic [AW-1:0] r_cnt;
    logic          r_done;

    assign o_addr = r_cnt;
    assign o_last = (r_cnt == '1);
    assign o_done = r_done;

    // Counter wraps to zero after the last write, ready for the next sweep.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= i_advance && o_last && !i_restart;
            if (i_restart) begin
                r_cnt <= '0;
            end else if (i_advance) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_ram_arbiter.sv
// rtl/frame_ram_arbiter.sv - single-port frame RAM arbiter: display read > clear > writer
module frame_ram_arbiter
    import frame_ram_arbiter_pkg::*;
#(
    parameter int COL_W = FB_COL_W,
    parameter int ROW_W = FB_ROW_W
) (
    input  logic               clk,
    input  logic               reset,
    frame_ram_arbiter_if.slave bus
);
    localparam int AW = COL_W + ROW_W;

    clear_state_t      r_state;
    clear_state_t      w_state_nxt;
    logic [PIX_W-1:0]  r_clear_color;
    logic [PIX_W-1:0]  r_pix;
    logic              r_p1_valid;
    logic              r_p1_hit;
    logic              r_pix_valid;

    logic              w_disp_hit;
    logic              w_clear_wr;
    logic              w_wr_ready;
    logic              w_wr_fire;
    logic              w_clear_last;
    logic              w_clear_done;
    logic [AW-1:0]     w_clear_addr;
    logic [AW-1:0]     w_ram_addr;
    logic              w_ram_we;
    logic [PIX_W-1:0]  w_ram_wdata;

    assign w_disp_hit = bus.disp_req
                     && ((bus.disp_x >> COL_W) == '0)
                     && ((bus.disp_y >> ROW_W) == '0);

    // A clear_start cycle never writes: it only restarts the sweep.
    assign w_clear_wr = reset && (r_state == ST_CLEAR) && !bus.clear_start && !w_disp_hit;
    assign w_wr_ready = reset && (r_state == ST_IDLE)  && !bus.clear_start && !w_disp_hit;
    assign w_wr_fire  = bus.wr_valid && w_wr_ready;

    frame_clear_seq #(.AW(AW)) u_clear_seq (
        .clk       (clk),
        .reset     (reset),
        .i_restart (bus.clear_start),
        .i_advance (w_clear_wr),
        .o_addr    (w_clear_addr),
        .o_last    (w_clear_last),
        .o_done    (w_clear_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.clear_start) w_state_nxt = ST_CLEAR;
            ST_CLEAR: begin
                if (bus.clear_start) begin
                    w_state_nxt = ST_CLEAR;
                end else if (w_clear_wr && w_clear_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ram_addr  = '0;
        w_ram_we    = 1'b0;
        w_ram_wdata = '0;
        if (w_disp_hit) begin
            w_ram_addr = {bus.disp_y[ROW_W-1:0], bus.disp_x[COL_W-1:0]};
        end else if (w_clear_wr) begin
            w_ram_addr  = w_clear_addr;
            w_ram_we    = 1'b1;
            w_ram_wdata = r_clear_color;
        end else if (w_wr_fire) begin
            w_ram_addr  = bus.wr_addr;
            w_ram_we    = 1'b1;
            w_ram_wdata = bus.wr_data;
        end
    end

    // Stage 1 tracks the request while the RAM reads; stage 2 captures rdata or black.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clear_color <= '0;
            r_p1_valid    <= 1'b0;
            r_p1_hit      <= 1'b0;
            r_pix_valid   <= 1'b0;
            r_pix         <= '0;
        end else begin
            if (bus.clear_start) begin
                r_clear_color <= bus.clear_color;
            end
            r_p1_valid  <= bus.disp_req;
            r_p1_hit    <= w_disp_hit;
            r_pix_valid <= r_p1_valid;
            r_pix       <= (r_p1_valid && r_p1_hit) ? bus.ram_rdata : '0;
        end
    end

    assign bus.r          = r_pix[3*COLOR_WIDTH-1:2*COLOR_WIDTH];
    assign bus.g          = r_pix[2*COLOR_WIDTH-1:COLOR_WIDTH];
    assign bus.b          = r_pix[COLOR_WIDTH-1:0];
    assign bus.pix_valid  = r_pix_valid;
    assign bus.wr_ready   = w_wr_ready;
    assign bus.clear_busy = (r_state == ST_CLEAR);
    assign bus.clear_done = w_clear_done;
    assign bus.ram_addr   = w_ram_addr;
    assign bus.ram_we     = w_ram_we;
    assign bus.ram_wdata  = w_ram_wdata;

endmodule

// File: doc/frame_ram_arbiter.md
FRAME_RAM_ARBITER -- requirements
Module: frame_ram_arbiter

Interface
REQ-001 Parameter COL_W, default 8, frame-buffer column address bits (buffer width 2^COL_W pixels).
REQ-002 Parameter ROW_W, default 8, frame-buffer row address bits (buffer height 2^ROW_W rows).
REQ-003 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 disp_req  in  1  display wants a pixel this cycle (sync-generator valid_data).
REQ-006 disp_x  in  log2NUM_COLS  display column; disp_y  in  log2NUM_ROWS  display row.
REQ-007 r, g, b  out  COLOR_WIDTH each  fetched pixel colour; pix_valid  out  1  r/g/b are meaningful.
REQ-008 wr_valid  in  1; wr_ready  out  1; wr_addr  in  COL_W+ROW_W  {row,col}; wr_data  in  3*COLOR_WIDTH  {r,g,b}.
REQ-009 clear_start  in  1  pulse; clear_color  in  3*COLOR_WIDTH; clear_busy  out  1; clear_done  out  1  one-cycle pulse.
REQ-010 ram_addr  out  COL_W+ROW_W; ram_we  out  1; ram_wdata  out  3*COLOR_WIDTH; ram_rdata  in  3*COLOR_WIDTH (external single-port RAM, 1-cycle read latency).

Function
REQ-011 Exactly one RAM access per cycle; priority: display read > clear write > writer write.
REQ-012 Display hit: disp_req=1 and disp_x < 2^COL_W and disp_y < 2^ROW_W; ram_addr={disp_y[ROW_W-1:0],disp_x[COL_W-1:0]}, ram_we=0.
REQ-013 Display miss (disp_req=1, coordinate out of range): no RAM access; cycle is free for clear/writer; pixel output is black.
REQ-014 Display latency is 2 cycles: request in cycle N -> r/g/b and pix_valid=1 registered at edge ending cycle N+1 (valid in N+2), for hits and misses alike.
REQ-015 pix_valid=0 forces r=g=b=0; display pipeline is never stalled.
REQ-016 FSM states IDLE and CLEAR; IDLE->CLEAR on clear_start; CLEAR->IDLE after last address written.
REQ-017 CLEAR: on each free cycle write clear_color (latched at clear_start) to clear counter address, then increment counter; counter starts at 0.
REQ-018 Write of address 2^(COL_W+ROW_W)-1 SHALL assert clear_done next cycle and return to IDLE; clear_busy=1 exactly while in CLEAR.
REQ-019 clear_start while in CLEAR restarts the counter at 0 and relatches clear_color; no clear_done for the aborted sweep.
REQ-020 wr_ready=1 only when state=IDLE, clear_start=0 and the cycle is free (no display hit); wr_ready is combinational.
REQ-021 Writer transfer occurs when wr_valid & wr_ready: ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data in that cycle.
REQ-022 Writer SHALL hold wr_valid/wr_addr/wr_data until accepted; block never drops or duplicates a transfer.
REQ-023 clear_start and wr_valid in same IDLE free cycle: writer not accepted; clear begins next cycle.
REQ-024 Idle free cycle with no write: ram_we=0, ram_addr=0.

Reset
REQ-025 reset low asynchronously forces: state=IDLE, clear counter=0, clear_busy=0, clear_done=0, pix_valid=0, r=g=b=0, display pipeline valid bits=0.
REQ-026 Reset mid-clear abandons the sweep without clear_done; RAM contents are not restored.
REQ-027 While reset is low ram_we=0 and wr_ready=0.

Structure
REQ-028 FB_COL_W, FB_ROW_W defaults and the IDLE/CLEAR state encoding belong in the shared defines file alongside COLOR_WIDTH and log2NUM_COLS/log2NUM_ROWS.
REQ-029 The clear address counter with its done detection is one sub-module, frame_clear_seq; all arbitration stays in frame_ram_arbiter.
REQ-030 The RAM is outside the block; bench uses a behavioural 1-cycle-latency RAM model.

Verification
REQ-031 Write {255,0,0} to addr 0x0102 with no display traffic -> wr_ready=1, accepted in one cycle; later disp_req at x=2,y=1 -> r=255,g=0,b=0, pix_valid=1 two cycles later.
REQ-032 disp_req held 1 with in-range coordinates, wr_valid=1 -> wr_ready stays 0; drop disp_req one cycle -> exactly one write accepted that cycle.
REQ-033 disp_x=300, COL_W=8 -> no RAM access, black pixel with pix_valid=1 after 2 cycles, pending write accepted that cycle.
REQ-034 clear_start with clear_color=0x00FF00, no display -> clear_busy for 65536 cycles, clear_done pulse once, all addresses read back 0x00FF00.
REQ-035 clear_start at counter=1000, then again -> sweep restarts at 0, single clear_done after full 65536 writes.
REQ-036 reset low mid-clear and mid-display -> all outputs zero immediately (asynchronous), state IDLE, no clear_done after release.
